// File: rtl/seg7_code_decoder.sv
// Debounced 7-segment pattern decoder: recovers digit index, one-hot and legality from an active-low seg bus.
// Define SEG_ERR_CNT_EN to build the saturating err_cnt_o register; otherwise err_cnt_o is tied to zero.
module seg7_code_decoder #(
    parameter int unsigned STABLE_CYCLES = 4,
    parameter int unsigned CNT_W         = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             en_i,
    input  logic [6:0]       seg_i,
    output logic [2:0]       y_o,
    output logic [7:0]       x_o,
    output logic             flag_o,
    output logic             valid_o,
    output logic             err_o,
    output logic [CNT_W-1:0] err_cnt_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] STABLE_N = 8'(STABLE_CYCLES);
    localparam logic       ONE_SHOT = (STABLE_CYCLES == 1);

    logic [6:0] seg_s1_q;
    logic [6:0] seg_s2_q;
    state_t     state_q;
    logic [6:0] cand_q;
    logic [7:0] cnt_q;
    logic [2:0] y_q;
    logic [7:0] x_q;
    logic       flag_q;
    logic       valid_q;
    logic       err_q;

    logic       dec_legal;
    logic [2:0] dec_code;
    logic       mismatch;
    logic       accept_d;

    // seg_i is asynchronous to clk_i; only seg_s2_q is used past this point
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            seg_s1_q <= '0;
            seg_s2_q <= '0;
        end else begin
            seg_s1_q <= seg_i;
            seg_s2_q <= seg_s1_q;
        end
    end

    always_comb begin
        dec_legal = 1'b1;
        dec_code  = 3'd0;
        case (seg_s2_q)
            7'b1000000: dec_code = 3'd0;
            7'b1111001: dec_code = 3'd1;
            7'b0100100: dec_code = 3'd2;
            7'b0110000: dec_code = 3'd3;
            7'b0011001: dec_code = 3'd4;
            7'b0010010: dec_code = 3'd5;
            7'b0000010: dec_code = 3'd6;
            7'b1111000: dec_code = 3'd7;
            default:    dec_legal = 1'b0;
        endcase
    end

    assign mismatch = (seg_s2_q != cand_q);

    // The sample being accepted is always seg_s2_q: either it matches cand_q or it reloads it
    always_comb begin
        accept_d = 1'b0;
        if (en_i) begin
            case (state_q)
                IDLE:    accept_d = ONE_SHOT;
                SETTLE:  accept_d = mismatch ? ONE_SHOT : ((cnt_q + 8'd1) == STABLE_N);
                LOCKED:  accept_d = mismatch && ONE_SHOT;
                default: accept_d = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            cand_q  <= '0;
            cnt_q   <= '0;
            y_q     <= '0;
            x_q     <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else if (!en_i) begin
            state_q <= IDLE;
            y_q     <= '0;
            x_q     <= '0;
            flag_q  <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            err_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    cand_q  <= seg_s2_q;
                    cnt_q   <= 8'd1;
                    state_q <= accept_d ? LOCKED : SETTLE;
                end
                SETTLE: begin
                    if (mismatch) begin
                        cand_q <= seg_s2_q;
                        cnt_q  <= 8'd1;
                    end else begin
                        cnt_q  <= cnt_q + 8'd1;
                    end
                    if (accept_d) state_q <= LOCKED;
                end
                LOCKED: begin
                    if (mismatch) begin
                        cand_q  <= seg_s2_q;
                        cnt_q   <= 8'd1;
                        state_q <= accept_d ? LOCKED : SETTLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
            if (accept_d) begin
                valid_q <= 1'b1;
                if (dec_legal) begin
                    y_q    <= dec_code;
                    x_q    <= 8'b1 << dec_code;
                    flag_q <= 1'b1;
                end else begin
                    y_q    <= '0;
                    x_q    <= '0;
                    flag_q <= 1'b0;
                    err_q  <= 1'b1;
                end
            end
        end
    end

`ifdef SEG_ERR_CNT_EN
    logic [CNT_W-1:0] err_cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_cnt_q <= '0;
        end else if (accept_d && !dec_legal && (err_cnt_q != {CNT_W{1'b1}})) begin
            err_cnt_q <= err_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign err_cnt_o = err_cnt_q;
`else
    assign err_cnt_o = '0;
`endif

    assign y_o     = y_q;
    assign x_o     = x_q;
    assign flag_o  = flag_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

// File: tb/tb_seg7_code_decoder.sv
// Bench for seg7_code_decoder: directed scenarios plus randomized seg/en traffic against a run-length reference model.
module tb_seg7_code_decoder;

    localparam int S  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          en  = 1'b0;
    logic [6:0]    seg = 7'h7f;
    logic [2:0]    y;
    logic [7:0]    x;
    logic          flag;
    logic          valid;
    logic          err;
    logic [CW-1:0] err_cnt;

    int checks = 0;
    int errors = 0;

    logic [6:0] codes [8] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};

    seg7_code_decoder #(.STABLE_CYCLES(S), .CNT_W(CW)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .en_i      (en),
        .seg_i     (seg),
        .y_o       (y),
        .x_o       (x),
        .flag_o    (flag),
        .valid_o   (valid),
        .err_o     (err),
        .err_cnt_o (err_cnt)
    );

    always #5 clk = ~clk;

    // Reference model: a pattern is accepted when the synchronized value has been seen on
    // exactly S consecutive enabled edges; the run restarts whenever the value changes or en drops.
    logic [6:0]    m_s1 = '0, m_s2 = '0, m_last = '0;
    int            m_run = 0;
    bit            m_on = 0;
    logic [2:0]    m_y = '0;
    logic [7:0]    m_x = '0;
    logic          m_flag = 0, m_valid = 0, m_err = 0;
    logic [CW-1:0] m_cnt = '0;

    initial forever begin
        logic [6:0] ss;
        int         idx;
        @(posedge clk or posedge rst);
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_last = '0; m_run = 0; m_on = 0;
            m_y = '0; m_x = '0; m_flag = 0; m_valid = 0; m_err = 0; m_cnt = '0;
        end else begin
            ss = m_s2;
            m_s2 = m_s1;
            m_s1 = seg;
            m_valid = 0;
            m_err = 0;
            if (!en) begin
                m_on = 0; m_run = 0; m_y = '0; m_x = '0; m_flag = 0;
            end else begin
                if (m_on && ss == m_last) m_run = m_run + 1;
                else m_run = 1;
                m_on = 1;
                m_last = ss;
                if (m_run == S) begin
                    idx = -1;
                    for (int i = 0; i < 8; i++) if (codes[i] == ss) idx = i;
                    m_valid = 1;
                    if (idx >= 0) begin
                        m_y = 3'(idx);
                        m_x = 8'(1 << idx);
                        m_flag = 1;
                    end else begin
                        m_y = '0; m_x = '0; m_flag = 0; m_err = 1;
`ifdef SEG_ERR_CNT_EN
                        if (m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
`endif
                    end
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    // Reset with en/seg already set, so the first edge after release is edge 1
    task automatic rst_start(input logic en_v, input logic [6:0] seg_v);
        @(negedge clk);
        rst = 1'b1;
        en  = en_v;
        seg = seg_v;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        en  = 1'b0;
        seg = 7'h7f;
        #1;
        checks++;
        if ({y, x, flag, valid, err} !== 14'd0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got y=%0d x=%02h flag=%0b valid=%0b err=%0b cnt=%0d want all 0",
                     y, x, flag, valid, err, err_cnt);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_first_accept();
        rst_start(1'b1, 7'b0110000);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (valid !== (k == 6)) begin
                errors++;
                $display("FAIL first_valid_edge%0d: got %0b want %0b", k, valid, (k == 6));
            end
        end
        checks++;
        if (y !== 3'd3 || x !== 8'b00001000 || flag !== 1'b1) begin
            errors++;
            $display("FAIL first_decode: got y=%0d x=%02h flag=%0b want y=3 x=08 flag=1", y, x, flag);
        end
        for (int k = 0; k < 10; k++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                errors++;
                $display("FAIL first_hold_no_revalid: got %0b want 0", valid);
            end
        end
    endtask

    task automatic test_all_codes();
        int nvalid = 0;
        rst_start(1'b1, codes[0]);
        for (int c = 0; c < 8; c++) begin
            seg = codes[c];
            for (int k = 0; k < 10; k++) begin
                tick();
                if (valid === 1'b1) begin
                    nvalid++;
                    checks++;
                    if (y !== 3'(c) || x !== 8'(1 << c) || flag !== 1'b1) begin
                        errors++;
                        $display("FAIL code_%0d_decode: got y=%0d x=%02h flag=%0b want y=%0d x=%02h flag=1",
                                 c, y, x, flag, c, 8'(1 << c));
                    end
                end
            end
        end
        checks++;
        if (nvalid !== 8) begin
            errors++;
            $display("FAIL all_codes_valid_count: got %0d want 8", nvalid);
        end
    endtask

    task automatic test_glitch();
        rst_start(1'b1, 7'b1111000);
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (y !== 3'd7 || flag !== 1'b1) begin
            errors++;
            $display("FAIL glitch_pre_lock: got y=%0d flag=%0b want y=7 flag=1", y, flag);
        end
        seg = 7'b0000000;
        tick();
        tick();
        seg = 7'b1111000;
        for (int k = 3; k <= 14; k++) begin
            tick();
            checks++;
            if (y !== 3'd7 || flag !== 1'b1 || err !== 1'b0) begin
                errors++;
                $display("FAIL glitch_hold_cycle%0d: got y=%0d flag=%0b err=%0b want y=7 flag=1 err=0",
                         k, y, flag, err);
            end
            checks++;
            if (k <= S + 2 ? (valid !== 1'b0) : (valid !== m_valid)) begin
                errors++;
                $display("FAIL glitch_valid_cycle%0d: got %0b want %0b", k, valid,
                         (k <= S + 2) ? 1'b0 : m_valid);
            end
        end
    endtask

    task automatic test_illegal();
        logic [CW-1:0] want_cnt;
`ifdef SEG_ERR_CNT_EN
        want_cnt = 1;
`else
        want_cnt = 0;
`endif
        rst_start(1'b1, 7'b1111111);
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (valid !== (k == 6) || err !== (k == 6)) begin
                errors++;
                $display("FAIL illegal_pulse_edge%0d: got valid=%0b err=%0b want %0b", k, valid, err, (k == 6));
            end
        end
        checks++;
        if (flag !== 1'b0 || x !== 8'd0 || y !== 3'd0 || err_cnt !== want_cnt) begin
            errors++;
            $display("FAIL illegal_outputs: got flag=%0b x=%02h y=%0d cnt=%0d want 0 0 0 %0d",
                     flag, x, y, err_cnt, want_cnt);
        end
    endtask

    task automatic test_en_toggle();
        rst_start(1'b1, codes[5]);
        for (int k = 0; k < 8; k++) tick();
        checks++;
        if (y !== 3'd5 || flag !== 1'b1) begin
            errors++;
            $display("FAIL en_pre_lock: got y=%0d flag=%0b want y=5 flag=1", y, flag);
        end
        en = 1'b0;
        tick();
        checks++;
        if ({y, x, flag, valid, err} !== 14'd0) begin
            errors++;
            $display("FAIL en_low_clear: got y=%0d x=%02h flag=%0b want all 0", y, x, flag);
        end
        tick();
        tick();
        en = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            checks++;
            if (valid !== (k == 4)) begin
                errors++;
                $display("FAIL en_reaccept_edge%0d: got %0b want %0b", k, valid, (k == 4));
            end
        end
        checks++;
        if (y !== 3'd5 || x !== 8'h20 || flag !== 1'b1) begin
            errors++;
            $display("FAIL en_reaccept_decode: got y=%0d x=%02h flag=%0b want y=5 x=20 flag=1", y, x, flag);
        end
    endtask

    task automatic test_rst_mid_settle();
        rst_start(1'b1, codes[2]);
        for (int k = 0; k < 8; k++) tick();
        seg = codes[6];
        for (int k = 0; k < 5; k++) tick();
        checks++;
        if (y !== 3'd2 || valid !== 1'b0) begin
            errors++;
            $display("FAIL settle_before_rst: got y=%0d valid=%0b want y=2 valid=0", y, valid);
        end
        rst = 1'b1;
        #1;
        checks++;
        if ({y, x, flag, valid, err} !== 14'd0 || err_cnt !== '0) begin
            errors++;
            $display("FAIL rst_async_clear: got y=%0d x=%02h flag=%0b want all 0", y, x, flag);
        end
        tick();
        rst = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            checks++;
            if (valid !== (k == 6)) begin
                errors++;
                $display("FAIL rst_relatency_edge%0d: got %0b want %0b", k, valid, (k == 6));
            end
        end
        checks++;
        if (y !== 3'd6 || x !== 8'h40 || flag !== 1'b1) begin
            errors++;
            $display("FAIL rst_reaccept_decode: got y=%0d x=%02h flag=%0b want y=6 x=40 flag=1", y, x, flag);
        end
    endtask

    task automatic test_random();
        int hold = 0;
        int off  = 0;
        rst_start(1'b1, codes[$urandom_range(7)]);
        for (int n = 0; n < 2000; n++) begin
            tick();
            checks++;
            if (y !== m_y || x !== m_x || flag !== m_flag) begin
                errors++;
                $display("FAIL rand_decode_cyc%0d: got y=%0d x=%02h flag=%0b want y=%0d x=%02h flag=%0b",
                         n, y, x, flag, m_y, m_x, m_flag);
            end
            checks++;
            if (valid !== m_valid || err !== m_err || err_cnt !== m_cnt) begin
                errors++;
                $display("FAIL rand_pulse_cyc%0d: got valid=%0b err=%0b cnt=%0d want %0b %0b %0d",
                         n, valid, err, err_cnt, m_valid, m_err, m_cnt);
            end
            if (hold == 0) begin
                if ($urandom_range(99) < 70) seg = codes[$urandom_range(7)];
                else seg = 7'($urandom);
                hold = $urandom_range(8, 1);
            end
            hold--;
            if (off > 0) begin
                off--;
                en = (off == 0);
            end else if ($urandom_range(99) < 3) begin
                off = $urandom_range(4, 1);
                en  = 1'b0;
            end
        end
        en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_first_accept();
        test_all_codes();
        test_glitch();
        test_illegal();
        test_en_toggle();
        test_rst_mid_settle();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
